float_discriminant_requester: RTL

- Requester (initiator) side of the float discriminant unit's arg_vld / busy / res_vld / err protocol.
- Accepts coefficient triples (a, b, c) from an upstream valid/ready stream and screens them for NaN/Inf.
- Issues each valid triple to the discriminant unit as a single-cycle arg_vld, waits for res_vld with a timeout, and holds the result on a downstream valid/ready stream.
- One triple in flight at a time.

---
 rtl/float_discriminant_requester_pkg.sv | 20 ++
 rtl/float_discriminant_requester.sv | 102 ++++++++++
 2 files changed

// File: rtl/float_discriminant_requester_pkg.sv
// rtl/float_discriminant_requester_pkg.sv - shared FP64 constants, FSM states and operand screening
package float_discriminant_requester_pkg;

  localparam int FLEN    = 64;
  localparam int EXP_MSB = 62;
  localparam int EXP_LSB = 52;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // An all-ones exponent encodes either an infinity or a NaN.
  function automatic logic is_nan_or_inf(input logic [FLEN-1:0] x);
    return &x[EXP_MSB:EXP_LSB];
  endfunction

endpackage

// File: rtl/float_discriminant_requester.sv
// rtl/float_discriminant_requester.sv - screens a/b/c triples, issues them to the discriminant unit, holds the result
module float_discriminant_requester
  import float_discriminant_requester_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [FLEN-1:0] in_a,
  input  logic [FLEN-1:0] in_b,
  input  logic [FLEN-1:0] in_c,
  output logic            disc_arg_vld,
  output logic [FLEN-1:0] disc_a,
  output logic [FLEN-1:0] disc_b,
  output logic [FLEN-1:0] disc_c,
  input  logic            disc_busy,
  input  logic            disc_res_vld,
  input  logic [FLEN-1:0] disc_res,
  input  logic            disc_res_negative,
  input  logic            disc_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [FLEN-1:0] out_res,
  output logic            out_negative,
  output logic            out_err,
  output logic            out_timeout
);

  localparam int             CW   = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  TMAX = CW'(TIMEOUT_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;

  assign in_ready     = (state == IDLE);
  assign out_valid    = (state == HOLD);
  assign disc_arg_vld = (state == ISSUE) && !disc_busy;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      disc_a       <= '0;
      disc_b       <= '0;
      disc_c       <= '0;
      out_res      <= '0;
      out_negative <= 1'b0;
      out_err      <= 1'b0;
      out_timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            disc_a <= in_a;
            disc_b <= in_b;
            disc_c <= in_c;
            // Non-finite operands are answered locally; the unit never sees them.
            if (is_nan_or_inf(in_a) || is_nan_or_inf(in_b) || is_nan_or_inf(in_c)) begin
              out_res      <= '0;
              out_negative <= 1'b0;
              out_err      <= 1'b1;
              out_timeout  <= 1'b0;
              state        <= HOLD;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (!disc_busy) begin
            cnt   <= '0;
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          // A result landing in the expiry cycle still counts as a result.
          if (disc_res_vld) begin
            out_res      <= disc_res;
            out_negative <= disc_res_negative;
            out_err      <= disc_err;
            out_timeout  <= 1'b0;
            state        <= HOLD;
          end else if (cnt == TMAX) begin
            out_res      <= '0;
            out_negative <= 1'b0;
            out_err      <= 1'b1;
            out_timeout  <= 1'b1;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
